// File: rtl/fatmeshy_pkg.sv
// Shared fatmeshy link types and constants used by the lane transmitter.
package fatmeshy_pkg;

    localparam int LINK_WORD_SIZE       = 28;
    localparam int LINK_TX_REJECT_CNT_W = 16;
    localparam logic [7:0] LINK_TX_IDLE_PATTERN = 8'hBC;

    typedef enum logic {
        LTX_IDLE = 1'b0,
        LTX_SEND = 1'b1
    } link_tx_state_t;

endpackage

// File: rtl/link_tx_fifo.sv
// Word FIFO for the lane transmitter; power-of-two depth, exposes occupancy.
module link_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int CW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [CW-1:0]               wr_ptr;
    logic [CW-1:0]               rd_ptr;

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/link_tx_lane.sv
// Serialises ARQ link words onto a narrow PHY lane, LSB beat first.
// Macro LINK_TX_LANE_IDLE_FILL_EN: drive IDLE_PATTERN fill beats while idle.
module link_tx_lane
    import fatmeshy_pkg::*;
#(
    parameter int LANE_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter logic [LANE_WIDTH-1:0] IDLE_PATTERN = LANE_WIDTH'(LINK_TX_IDLE_PATTERN)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [LINK_WORD_SIZE-1:0]       word_data,
    input  logic                            word_valid,
    input  logic                            word_prio,
    output logic                            word_accept,
    output logic                            word_reject,
    output logic [LANE_WIDTH-1:0]           lane_data,
    output logic                            lane_valid,
    output logic                            lane_first,
    output logic                            lane_idle,
    input  logic                            lane_ready,
    output logic [LINK_TX_REJECT_CNT_W-1:0] reject_count
);
    localparam int BEATS = (LINK_WORD_SIZE + LANE_WIDTH - 1) / LANE_WIDTH;
    localparam int SHW   = BEATS * LANE_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(DEPTH);
    localparam logic [CW:0]   FULL_LVL  = (CW+1)'(DEPTH);
    localparam logic [CW:0]   RSVD_LVL  = (CW+1)'(DEPTH - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
`ifdef LINK_TX_LANE_IDLE_FILL_EN
    localparam bit IDLE_FILL = 1'b1;
`else
    localparam bit IDLE_FILL = 1'b0;
`endif

    link_tx_state_t            state, state_nxt;
    logic [SHW-1:0]            shreg;
    logic [BW-1:0]             beat_cnt;
    logic [LINK_WORD_SIZE-1:0] fifo_head;
    logic [CW:0]               fifo_count;
    logic                      fifo_empty;
    logic                      load, shift;
    logic                      started;

    // Admission looks only at registered occupancy; the top slot is prio-only.
    assign word_accept = word_valid && (word_prio ? (fifo_count < FULL_LVL)
                                                  : (fifo_count < RSVD_LVL));
    assign word_reject = word_valid && !word_accept;

    link_tx_fifo #(
        .WIDTH (LINK_WORD_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (word_accept),
        .push_data (word_data),
        .pop       (load),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LTX_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        lane_valid = 1'b0;
        lane_first = 1'b0;
        lane_idle  = 1'b0;
        lane_data  = '0;
        state_nxt  = state;
        load       = 1'b0;
        shift      = 1'b0;
        if (state == LTX_SEND) begin
            lane_valid = 1'b1;
            lane_first = (beat_cnt == '0);
            lane_data  = shreg[LANE_WIDTH-1:0];
        end else if (IDLE_FILL && started) begin
            lane_valid = 1'b1;
            lane_idle  = 1'b1;
            lane_data  = IDLE_PATTERN;
        end
        case (state)
            LTX_IDLE: begin
                // A visible idle beat must be consumed before a word replaces it.
                if (!fifo_empty && (!lane_valid || lane_ready)) begin
                    state_nxt = LTX_SEND;
                    load      = 1'b1;
                end
            end
            LTX_SEND: begin
                if (lane_ready) begin
                    if (beat_cnt == LAST_BEAT) begin
                        if (!fifo_empty) load      = 1'b1;
                        else             state_nxt = LTX_IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = LTX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            shreg    <= SHW'(fifo_head);
            beat_cnt <= '0;
        end else if (shift) begin
            shreg    <= shreg >> LANE_WIDTH;
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Idle fill stays off for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) started <= 1'b0;
        else        started <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            reject_count <= '0;
        else if (word_reject && reject_count != '1)
            reject_count <= reject_count + 1'b1;
    end

endmodule

// File: tb/tb_link_tx_lane.sv
// Bench for link_tx_lane: beat-queue reference model plus directed literal checks.
module tb_link_tx_lane;
    import fatmeshy_pkg::*;

    localparam int LW    = 8;
    localparam int DEP   = 4;
    localparam int BEATS = (LINK_WORD_SIZE + LW - 1) / LW;
`ifdef LINK_TX_LANE_IDLE_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [LINK_WORD_SIZE-1:0] word_data;
    logic                      word_valid, word_prio, lane_ready;
    logic                      word_accept, word_reject;
    logic [LW-1:0]             lane_data;
    logic                      lane_valid, lane_first, lane_idle;
    logic [15:0]               reject_count;

    int n_cmp = 0;
    int n_bad = 0;

    link_tx_lane #(.LANE_WIDTH(LW), .DEPTH(DEP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_prio    (word_prio),
        .word_accept  (word_accept),
        .word_reject  (word_reject),
        .lane_data    (lane_data),
        .lane_valid   (lane_valid),
        .lane_first   (lane_first),
        .lane_idle    (lane_idle),
        .lane_ready   (lane_ready),
        .reject_count (reject_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words waiting, and the remaining beats of the word on the lane.
    logic [LINK_WORD_SIZE-1:0] m_q[$];
    logic [LW-1:0]             m_cur[$];
    int                        m_idx = 0;
    bit                        m_started = 1'b0;
    int                        m_rej = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_cur.delete();
            m_idx = 0;
            m_started = 1'b0;
            m_rej = 0;
        end else begin
            bit acc, vld_now, need_load;
            logic [BEATS*LW-1:0] ext;
            acc = word_valid && (word_prio ? (m_q.size() < DEP) : (m_q.size() < DEP - 1));
            if (word_valid && !acc && m_rej < 65535) m_rej++;
            vld_now = (m_cur.size() > 0) || (FILL && m_started);
            need_load = 1'b0;
            if (m_cur.size() > 0) begin
                if (lane_ready) begin
                    if (m_cur.size() == 1) need_load = 1'b1;
                    void'(m_cur.pop_front());
                    m_idx++;
                end
            end else if (!vld_now || lane_ready) begin
                need_load = 1'b1;
            end
            if (need_load && m_q.size() > 0) begin
                ext = '0;
                ext[LINK_WORD_SIZE-1:0] = m_q.pop_front();
                for (int b = 0; b < BEATS; b++) m_cur.push_back(ext[b*LW +: LW]);
                m_idx = 0;
            end
            if (acc) m_q.push_back(word_data);
            m_started = 1'b1;
        end
    end

    // Cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            bit e_acc, e_vld, e_idle;
            logic [LW-1:0] e_data;
            e_acc  = word_valid && (word_prio ? (m_q.size() < DEP) : (m_q.size() < DEP - 1));
            e_vld  = (m_cur.size() > 0) || (FILL && m_started);
            e_idle = (m_cur.size() == 0) && FILL && m_started;
            e_data = (m_cur.size() > 0) ? m_cur[0] : (e_idle ? 8'hBC : 8'h00);
            chk("accept", 32'(word_accept), 32'(e_acc));
            chk("reject", 32'(word_reject), 32'(word_valid && !e_acc));
            chk("lane_valid", 32'(lane_valid), 32'(e_vld));
            chk("lane_idle", 32'(lane_idle), 32'(e_idle));
            chk("lane_first", 32'(lane_first), 32'((m_cur.size() > 0) && (m_idx == 0)));
            chk("lane_data", 32'(lane_data), 32'(e_data));
            chk("reject_count", 32'(reject_count), 32'(m_rej));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int  nacc, nbeats;
    bit  found;

    initial begin
        rst_n = 1'b0; word_valid = 1'b0; word_prio = 1'b0; word_data = '0; lane_ready = 1'b0;
        repeat (2) cyc();
        chk("rst_valid", 32'(lane_valid), 0);
        chk("rst_first", 32'(lane_first), 0);
        chk("rst_idle", 32'(lane_idle), 0);
        chk("rst_data", 32'(lane_data), 0);
        chk("rst_rejcnt", 32'(reject_count), 0);
        rst_n = 1'b1;
        repeat (2) cyc();

        // Single word, first beat two cycles after acceptance.
        lane_ready = 1'b1; word_valid = 1'b1; word_data = 28'h7E3C2A5;
        @(negedge clk) chk("w0_accept", 32'(word_accept), 1);
        cyc(); word_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("w0_first", 32'(lane_first), 1);
        chk("w0_beat0", 32'(lane_data), 32'h A5);
        @(negedge clk) chk("w0_beat1", 32'(lane_data), 32'h C2);
        @(negedge clk) chk("w0_beat2", 32'(lane_data), 32'h E3);
        @(negedge clk) chk("w0_beat3_pad", 32'(lane_data), 32'h 07);
        repeat (4) cyc();

        // Stalled lane: fill the FIFO and exercise the reserved slot.
        lane_ready = 1'b0;
        if (!FILL) begin
            word_valid = 1'b1; word_data = 28'h1111101;
            cyc(); word_valid = 1'b0;
            repeat (2) cyc();
        end
        nacc = 0;
        for (int i = 0; i < 4; i++) begin
            word_valid = 1'b1; word_prio = 1'b0; word_data = 28'h2222200 | 28'(i + 2);
            @(negedge clk) if (word_accept) nacc++;
            cyc();
        end
        word_valid = 1'b0;
        @(negedge clk);
        chk("np_accepts", 32'(nacc), 3);
        chk("rejcnt_1", 32'(reject_count), 1);
        cyc();
        word_valid = 1'b1; word_prio = 1'b1; word_data = 28'h3333306;
        @(negedge clk) chk("prio_accept", 32'(word_accept), 1);
        cyc(); word_data = 28'h3333307;
        @(negedge clk) chk("prio_reject", 32'(word_reject), 1);
        cyc(); word_valid = 1'b0; word_prio = 1'b0;
        @(negedge clk) chk("rejcnt_2", 32'(reject_count), 2);

        // Toggle lane_ready while draining; the model tracks every beat.
        nbeats = 0;
        for (int i = 0; i < 100; i++) begin
            lane_ready = (i % 2 == 1);
            @(negedge clk) if (lane_valid && lane_ready && !lane_idle) nbeats++;
            cyc();
        end
        chk("drain_beats", 32'(nbeats), 32'((FILL ? 4 : 5) * BEATS));
        lane_ready = 1'b1;
        repeat (3) cyc();

        if (FILL) begin
            @(negedge clk);
            chk("fill_valid", 32'(lane_valid), 1);
            chk("fill_idle", 32'(lane_idle), 1);
            chk("fill_data", 32'(lane_data), 32'h BC);
            cyc(); lane_ready = 1'b0; word_valid = 1'b1; word_data = 28'h44444C7;
            cyc(); word_valid = 1'b0;
            repeat (3) cyc();
            @(negedge clk) chk("fill_held", 32'(lane_idle), 1);
            cyc(); lane_ready = 1'b1;
            @(negedge clk);
            chk("fill_replace_first", 32'(lane_first), 1);
            chk("fill_replace_data", 32'(lane_data), 32'h C7);
            repeat (6) cyc();
        end

        // Reset mid-word at beat 2.
        lane_ready = 1'b1; word_valid = 1'b1; word_data = 28'hABCDE11;
        cyc(); word_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (lane_first) begin found = 1'b1; break; end
        end
        chk("mid_found_first", 32'(found), 1);
        @(negedge clk);
        @(negedge clk) chk("mid_beat2", 32'(lane_data), 32'h BC);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(lane_valid), 0);
        chk("arst_data", 32'(lane_data), 0);
        chk("arst_first", 32'(lane_first), 0);
        chk("arst_idle", 32'(lane_idle), 0);
        chk("arst_rejcnt", 32'(reject_count), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        if (!FILL) begin
            @(negedge clk) chk("post_rst_empty", 32'(lane_valid), 0);
            cyc();
        end
        word_valid = 1'b1; word_data = 28'h0000F5A;
        cyc(); word_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("post_rst_first", 32'(lane_first), 1);
        chk("post_rst_data", 32'(lane_data), 32'h 5A);
        repeat (6) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
